// File: rtl/fm_sb_word_packer.sv
// fm_sb_word_packer
// Captures fm_rt tap samples (fm_data/fm_vld) into a small sample FIFO and
// serialises each sample into AXI_DW-wide words, LS word first, for the FM
// spy buffer write port. The tap is never back-pressured: samples arriving
// on a full FIFO are dropped and counted in drop_cnt (saturating).
// Optional feature: define FM_SB_PACKER_HDR_EN to prefix every packet with a
// header word {seq[15:0], N_WORDS[7:0], drop_cnt[7:0]} (needs AXI_DW >= 32).
module fm_sb_word_packer #(
    parameter int MON_DW     = 256,
    parameter int SB_DW      = 51,
    parameter int AXI_DW     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_enable,
    input  logic [MON_DW-1:0] fm_data,
    input  logic              fm_vld,
    output logic [AXI_DW-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [15:0]       drop_cnt,
    output logic              overflow,
    output logic              busy
);

    localparam int N_WORDS = (SB_DW + AXI_DW - 1) / AXI_DW;
`ifdef FM_SB_PACKER_HDR_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif
    localparam int PKT_WORDS = N_WORDS + HDR_WORDS;
    localparam int SR_W      = PKT_WORDS * AXI_DW;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int IDX_W     = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Sample FIFO storage and bookkeeping
    logic [SB_DW-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Serialiser state
    state_t           state;
    logic [SR_W-1:0]  shreg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [SR_W-1:0]  load_word;

    logic fifo_full;
    logic fifo_empty;
    logic take;
    logic push;
    logic pop;
    logic word_done;
    logic last_done;

    // Bits of the monitor bus above SB_DW are intentionally ignored.
    logic unused_fm_data;
    assign unused_fm_data = ^fm_data;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign take       = fm_vld && sb_enable;
    // Full is judged before any same-cycle pop, so a pop never makes room.
    assign push       = take && !fifo_full;
    assign word_done  = out_valid && out_ready;
    assign last_done  = word_done && (idx == LAST_IDX);
    // Pop when idle, or on the final word handshake for a bubble-free reload.
    assign pop        = !fifo_empty && ((state == S_IDLE) || last_done);
    assign next_idx   = idx + 1'b1;

`ifdef FM_SB_PACKER_HDR_EN
    logic [15:0] seq;
    logic [31:0] hdr;
    assign hdr       = {seq, 8'(N_WORDS), drop_cnt[7:0]};
    assign load_word = {(SR_W-AXI_DW)'(mem[rd_ptr]), AXI_DW'(hdr)};

    // Packet sequence number, advanced once per popped sample
    always_ff @(posedge clk) begin
        if (rst)      seq <= '0;
        else if (pop) seq <= seq + 16'd1;
    end
`else
    assign load_word = SR_W'(mem[rd_ptr]);
`endif

    assign out_data = shreg[AXI_DW-1:0];
    assign busy     = !fifo_empty || (state != S_IDLE);

    // FIFO payload write
    // NOTE: storage is not reset; an entry is only read after it was written,
    // so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fm_data[SB_DW-1:0];
    end

    // FIFO pointers and occupancy
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop accounting: saturating counter plus sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (take && fifo_full) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            overflow <= 1'b1;
        end
    end

    // Serialiser FSM: load a sample, emit its words LS first, reload or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (pop) begin
            state     <= S_SEND;
            shreg     <= load_word;
            idx       <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == '0);
        end else if (last_done) begin
            state     <= S_IDLE;
            shreg     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (word_done) begin
            shreg     <= shreg >> AXI_DW;
            idx       <= next_idx;
            out_last  <= (next_idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_fm_sb_word_packer.sv
// Testbench for fm_sb_word_packer: directed scenarios plus randomized traffic,
// all checked against a transaction-level model (sample queue + word list).
// Define FM_SB_PACKER_HDR_EN for both bench and RTL to exercise the header.
module tb_fm_sb_word_packer;

    localparam int MON_DW     = 256;
    localparam int SB_DW      = 51;
    localparam int AXI_DW     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int N_WORDS    = (SB_DW + AXI_DW - 1) / AXI_DW;

    logic              clk;
    logic              rst;
    logic              sb_enable;
    logic [MON_DW-1:0] fm_data;
    logic              fm_vld;
    logic [AXI_DW-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [15:0]       drop_cnt;
    logic              overflow;
    logic              busy;

    fm_sb_word_packer #(
        .MON_DW(MON_DW), .SB_DW(SB_DW), .AXI_DW(AXI_DW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .sb_enable(sb_enable), .fm_data(fm_data),
        .fm_vld(fm_vld), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .drop_cnt(drop_cnt),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [MON_DW-1:0] m_fifo[$];
    logic [AXI_DW-1:0] m_words[$];
    logic              m_lasts[$];
    int                m_drop;
    bit                m_ovf;
    logic [15:0]       m_seq;

    // Words actually accepted by the sink, with their last flag
    logic [AXI_DW-1:0] seen_data[$];
    logic              seen_last[$];

    logic [MON_DW-1:0] sb_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MON_DW-1:0] rnd_data();
        logic [MON_DW-1:0] d;
        for (int i = 0; i < MON_DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock cycle: drive inputs at the negedge, compare the DUT outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input bit v, input logic [MON_DW-1:0] d, input bit en,
                        input bit rdy, input bit r);
        bit hs, do_pop, full;
        int drop_pre;
        logic [MON_DW-1:0] s;
        fm_vld = v; fm_data = d; sb_enable = en; out_ready = rdy; rst = r;
        check("valid", 32'(out_valid), 32'(m_words.size() > 0));
        if (m_words.size() > 0) begin
            check("data", out_data, m_words[0]);
            check("last", 32'(out_last), 32'(m_lasts[0]));
        end
        check("busy", 32'(busy), 32'((m_fifo.size() > 0) || (m_words.size() > 0)));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (out_valid && rdy) begin
            seen_data.push_back(out_data);
            seen_last.push_back(out_last);
        end
        @(posedge clk);
        if (r) begin
            m_fifo.delete(); m_words.delete(); m_lasts.delete();
            m_drop = 0; m_ovf = 0; m_seq = '0;
        end else begin
            hs       = (m_words.size() > 0) && rdy;
            do_pop   = (m_fifo.size() > 0) &&
                       ((m_words.size() == 0) || (hs && m_words.size() == 1));
            full     = (m_fifo.size() >= FIFO_DEPTH);
            drop_pre = m_drop;
            if (hs) begin
                void'(m_words.pop_front());
                void'(m_lasts.pop_front());
            end
            if (do_pop) begin
                s = m_fifo.pop_front();
`ifdef FM_SB_PACKER_HDR_EN
                m_words.push_back({m_seq, 8'(N_WORDS), 8'(drop_pre)});
                m_lasts.push_back(1'b0);
                m_seq = m_seq + 16'd1;
`endif
                for (int i = 0; i < N_WORDS; i++) begin
                    m_words.push_back(AXI_DW'(s >> (AXI_DW * i)));
                    m_lasts.push_back(i == N_WORDS - 1);
                end
            end
            if (v && en) begin
                if (full) begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end else begin
                    m_fifo.push_back(d & sb_mask);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, rnd_data(), 1'b1, rdy, 1'b0);
    endtask

    // Run with out_ready=1 until the DUT reports idle, within a cycle budget.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            idle_step(1'b1);
            n++;
        end
        check({tag, "_drain_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MON_DW-1:0] d;
        int vcount;
        clk = 1'b0; rst = 1'b1; sb_enable = 1'b0; fm_vld = 1'b0;
        fm_data = '0; out_ready = 1'b0;
        sb_mask = {MON_DW{1'b1}} >> (MON_DW - SB_DW);
        m_drop = 0; m_ovf = 0; m_seq = '0;
        @(negedge clk);

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

`ifndef FM_SB_PACKER_HDR_EN
        // Known sample, junk above SB_DW; first word visible after edge t+1
        d = rnd_data();
        d[SB_DW-1:0] = 51'h7_1234_5678_9ABC;
        step(1'b1, d, 1'b1, 1'b1, 1'b0);
        check("t1_lat_t", 32'(out_valid), 32'd0);
        idle_step(1'b1);
        check("t1_w0_valid", 32'(out_valid), 32'd1);
        check("t1_w0_data", out_data, 32'h56789ABC);
        check("t1_w0_last", 32'(out_last), 32'd0);
        idle_step(1'b1);
        check("t1_w1_data", out_data, 32'h00071234);
        check("t1_w1_last", 32'(out_last), 32'd1);
        idle_step(1'b1);
        check("t1_done", 32'(out_valid), 32'd0);

        // Burst of 7 with the sink stalled: one sample in the serialiser,
        // four queued, two dropped
        for (int i = 0; i < 7; i++) step(1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
        check("t2_drop", 32'(drop_cnt), 32'd2);
        check("t2_ovf", 32'(overflow), 32'd1);
        seen_data.delete(); seen_last.delete();
        drain("t2", 40);
        check("t2_words", seen_data.size(), 5 * N_WORDS);

        // Stall pattern mid-packet
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b1);
        drain("t3", 20);

        // Reset during word 0
        step(1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle_step(1'b0);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        step(1'b0, rnd_data(), 1'b1, 1'b0, 1'b1);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        seen_data.delete(); seen_last.delete();
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        drain("t5", 20);
        check("t5_words", seen_data.size(), N_WORDS);

        // Disabled tap ignores fm_vld entirely
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
            if (out_valid) vcount++;
        end
        check("t4_no_out", vcount, 0);
        check("t4_drop", 32'(drop_cnt), 32'd0);
        // Enable dropped mid-packet: packet still completes
        seen_data.delete(); seen_last.delete();
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
        step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
        drain("t4", 20);
        check("t4_words", seen_data.size(), N_WORDS);
`else
        // Header: two back-to-back samples
        seen_data.delete(); seen_last.delete();
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        drain("t6", 30);
        check("t6_words", seen_data.size(), 2 * (N_WORDS + 1));
        if (seen_data.size() == 2 * (N_WORDS + 1)) begin
            check("t6_hdr0", seen_data[0], 32'h0000_0200);
            check("t6_hdr1", seen_data[N_WORDS + 1], 32'h0001_0200);
            check("t6_hdr0_last", 32'(seen_last[0]), 32'd0);
            check("t6_tail0_last", 32'(seen_last[N_WORDS]), 32'd1);
        end
`endif

        // Randomized traffic in phases of varying input rate and sink stall
        for (int ph = 0; ph < 8; ph++) begin
            int vp = $urandom_range(10, 90);
            int rp = $urandom_range(20, 100);
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 99) < vp), rnd_data(),
                     ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < rp),
                     ($urandom_range(0, 999) == 0));
            end
        end
        drain("rand", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
